// File: rtl/fp_addsub_if.sv
// Start/done handshake bundle for the sequential FP add/subtract unit.
// The master issues operands and the slave returns busy/done/result.
interface fp_addsub_if;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (output start, op_sub, a, b, input busy, done, result);
    modport slave  (input start, op_sub, a, b, output busy, done, result);
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single add/subtract: 1-bit/cycle alignment and normalisation.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_addsub_seq #(
    parameter int          MAX_ALIGN = 26,
    parameter logic [31:0] QNAN      = 32'h7FC00000
) (
    input  logic       clk,
    input  logic       rst_n,
    fp_addsub_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;

    localparam logic [7:0] MAX_D = 8'(MAX_ALIGN);

    state_t      state, state_nx;
    logic [31:0] a_r, b_r;
    logic        sa, sb, rs;
    logic [7:0]  d;
    logic [26:0] ma, mb;
    logic [27:0] sum;
    logic [9:0]  re;
    logic [31:0] result;
    logic        done;

    // Mantissa layout: {hidden, frac[22:0], G, R, S}; sum adds a carry bit on top.
    logic [7:0]  ea_u, eb_u;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [26:0] ma_u, mb_u;

    assign ea_u   = a_r[30:23];
    assign eb_u   = b_r[30:23];
    assign a_zero = (ea_u == 8'h00);
    assign b_zero = (eb_u == 8'h00);
    assign a_inf  = (ea_u == 8'hFF) && (a_r[22:0] == 23'd0);
    assign b_inf  = (eb_u == 8'hFF) && (b_r[22:0] == 23'd0);
    assign a_nan  = (ea_u == 8'hFF) && (a_r[22:0] != 23'd0);
    assign b_nan  = (eb_u == 8'hFF) && (b_r[22:0] != 23'd0);
    assign ma_u   = a_zero ? 27'd0 : {1'b1, a_r[22:0], 3'b000};
    assign mb_u   = b_zero ? 27'd0 : {1'b1, b_r[22:0], 3'b000};

    logic        spec;
    logic [31:0] spec_res;

    always_comb begin
        spec     = 1'b1;
        spec_res = 32'd0;
        if (a_nan || b_nan)
            spec_res = QNAN;
        else if (a_inf && b_inf)
            spec_res = (a_r[31] != b_r[31]) ? QNAN : a_r;
        else if (a_inf)
            spec_res = a_r;
        else if (b_inf)
            spec_res = b_r;
        else if (a_zero && b_zero)
            spec_res = {a_r[31] & b_r[31], 31'd0};
        else
            spec = 1'b0;
    end

    logic [27:0] add_sum;
    logic        add_sign;

    always_comb begin
        if (sa == sb) begin
            add_sum  = {1'b0, ma} + {1'b0, mb};
            add_sign = sa;
        end else if (ma >= mb) begin
            add_sum  = {1'b0, ma - mb};
            add_sign = sa;
        end else begin
            add_sum  = {1'b0, mb - ma};
            add_sign = sb;
        end
    end

    logic        inc;
    logic [24:0] rnd;
    logic [9:0]  re_r;
    logic [22:0] frac_r;
    logic [31:0] rnd_res;

`ifdef FP_ADDSUB_RNE_EN
    assign inc = sum[2] & (sum[1] | sum[0] | sum[3]);
`else
    assign inc = 1'b0;
`endif

    always_comb begin
        rnd     = {1'b0, sum[26:3]} + {24'd0, inc};
        re_r    = re + {9'd0, rnd[24]};
        // A rounding carry leaves exactly 1.000..0, so the fraction is zero.
        frac_r  = rnd[24] ? 23'd0 : rnd[22:0];
        rnd_res = (re_r >= 10'd255) ? {rs, 8'hFF, 23'd0} : {rs, re_r[7:0], frac_r};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (bus.start) state_nx = UNPACK;
            UNPACK: state_nx = spec ? IDLE : ALIGN;
            ALIGN:  if (d == 8'd0 || d == 8'd1 || d > MAX_D) state_nx = ADD;
            ADD:    state_nx = (add_sum == 28'd0) ? IDLE : NORM;
            NORM: begin
                if (sum[27] || sum[26]) state_nx = ROUND;
                else if (re <= 10'd1)   state_nx = IDLE;
            end
            ROUND:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    a_r <= bus.a;
                    b_r <= {bus.b[31] ^ bus.op_sub, bus.b[30:0]};
                end
                UNPACK: begin
                    if (spec) begin
                        result <= spec_res;
                        done   <= 1'b1;
                    end else if (eb_u > ea_u) begin
                        sa <= b_r[31];  sb <= a_r[31];
                        ma <= mb_u;     mb <= ma_u;
                        re <= {2'b00, eb_u};
                        d  <= eb_u - ea_u;
                    end else begin
                        sa <= a_r[31];  sb <= b_r[31];
                        ma <= ma_u;     mb <= mb_u;
                        re <= {2'b00, ea_u};
                        d  <= ea_u - eb_u;
                    end
                end
                ALIGN: begin
                    if (d > MAX_D) begin
                        mb <= {26'd0, |mb};
                        d  <= 8'd0;
                    end else if (d != 8'd0) begin
                        mb <= {1'b0, mb[26:2], mb[1] | mb[0]};
                        d  <= d - 8'd1;
                    end
                end
                ADD: begin
                    if (add_sum == 28'd0) begin
                        result <= 32'd0;
                        done   <= 1'b1;
                    end else begin
                        sum <= add_sum;
                        rs  <= add_sign;
                    end
                end
                NORM: begin
                    if (sum[27]) begin
                        sum <= {1'b0, sum[27:2], sum[1] | sum[0]};
                        re  <= re + 10'd1;
                    end else if (!sum[26]) begin
                        if (re > 10'd1) begin
                            sum <= {sum[26:0], 1'b0};
                            re  <= re - 10'd1;
                        end else begin
                            // Result would be subnormal: flush.
                            result <= {rs, 31'd0};
                            done   <= 1'b1;
                        end
                    end
                end
                ROUND: begin
                    result <= rnd_res;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE) || done;
    assign bus.done   = done;
    assign bus.result = result;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Random + directed bench for fp_addsub_seq against an exact-arithmetic model.
module tb_fp_addsub_seq;
    logic clk = 1'b0;
    logic rst_n;
    fp_addsub_if bus ();

    fp_addsub_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        bit          lit_en;
        logic [31:0] lit;
        int          acc;
        int          maxlat;
        bit          exact;
    } tx_t;

    tx_t  txq [0:1023];
    int   tx_cnt = 0;
    int   rd = 0;
    int   cyc = 0;
    logic rst_q;
    int   total = 0;
    int   bad = 0;
    logic [31:0] last_res = 32'd0;

    localparam logic [31:0] SP [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                       32'h7FC00001, 32'h00000001, 32'h7F7FFFFF, 32'h00800000};

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    // Exact reference: align with wide integers, then round the true value once.
    function automatic logic [31:0] model(input logic [31:0] a0, input logic [31:0] b0, input logic sub);
        logic [31:0]  a, b, t;
        logic [127:0] x, y, s, mant, rem, half;
        int ea, eb, d, k, base, p, ef, sh;
        logic rs, up;
        a = a0;
        b = b0;
        b[31] = b0[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
        if (eb == 0) return a;
        if (ea == 0) return b;
        if (eb > ea) begin
            t = a; a = b; b = t;
            k = ea; ea = eb; eb = k;
        end
        d = ea - eb;
        k = (d > 64) ? 64 : d;
        x = {104'd0, 1'b1, a[22:0]} << k;
        // Far below half an ulp of a: only its non-zeroness matters.
        y = (d > 64) ? 128'd1 : {104'd0, 1'b1, b[22:0]};
        base = ea - k;
        if (a[31] == b[31])  begin s = x + y; rs = a[31]; end
        else if (x >= y)     begin s = x - y; rs = a[31]; end
        else                 begin s = y - x; rs = b[31]; end
        if (s == 0) return 32'd0;
        p = 127;
        while (!s[p]) p--;
        ef = base + p - 23;
        if (ef <= 0) return {rs, 31'd0};
        sh = p - 23;
        if (sh > 0) begin
            mant = s >> sh;
            rem  = s & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
`ifdef FP_ADDSUB_RNE_EN
            up = (rem > half) || (rem == half && mant[0]);
`else
            up = 1'b0;
`endif
            mant = mant + {127'd0, up};
        end else begin
            mant = s << (-sh);
        end
        if (mant[24]) begin
            mant = mant >> 1;
            ef++;
        end
        if (ef >= 255) return {rs, 8'hFF, 23'd0};
        return {rs, ef[7:0], mant[22:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: owns every check and the scoreboard read pointer.
    always @(negedge clk) begin : cmp
        tx_t t;
        int  lat;
        if (rst_q == 1'b0) begin
            rd = tx_cnt;
            last_res = 32'd0;
            chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
            chk("rst_done",   {31'd0, bus.done}, 32'd0);
            chk("rst_result", bus.result, 32'd0);
        end else if (rst_q == 1'b1) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, rd != tx_cnt});
            if (bus.done) begin
                if (rd == tx_cnt) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: result %h with nothing outstanding", bus.result);
                end else begin
                    t = txq[rd];
                    rd++;
                    chk("result", bus.result, t.exp);
                    if (t.lit_en) chk("literal", bus.result, t.lit);
                    lat = cyc - t.acc + 1;
                    total++;
                    if (t.exact ? (lat != t.maxlat) : (lat > t.maxlat)) begin
                        bad++;
                        $display("FAIL latency: got %0d required %s%0d", lat, t.exact ? "" : "<=", t.maxlat);
                    end
                    last_res = t.exp;
                end
            end else begin
                chk("hold", bus.result, last_res);
                if (rd != tx_cnt && cyc - txq[rd].acc > 60) begin
                    total++;
                    bad++;
                    $display("FAIL timeout: no done for op accepted at cycle %0d", txq[rd].acc);
                    rd++;
                end
            end
        end
    end

    // Call at a negedge where the DUT will accept; returns at the done negedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input bit lit_en, input logic [31:0] lit, input int maxlat,
                         input bit exact, input bit junk);
        bus.start  = 1'b1;
        bus.a      = a;
        bus.b      = b;
        bus.op_sub = sub;
        @(posedge clk);
        txq[tx_cnt] = '{model(a, b, sub), lit_en, lit, cyc + 1, maxlat, exact};
        tx_cnt++;
        #1;
        if (junk) begin
            bus.a      = $urandom;
            bus.b      = $urandom;
            bus.op_sub = 1'($urandom_range(0, 1));
        end else begin
            bus.start = 1'b0;
        end
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        int m;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h3F800000, 32'h3F800000, 1'b1, 1, 32'h00000000, 6, 0, 0);
        issue(32'h40400000, 32'h3F800000, 1'b1, 1, 32'h40000000, 54, 0, 1);
        issue(32'h3F800000, 32'h30800000, 1'b0, 1, 32'h3F800000, 7, 0, 0);
        issue(32'h7F800000, 32'h7F800000, 1'b1, 1, 32'h7FC00000, 2, 1, 0);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1, 32'h7F800000, 54, 0, 0);
`ifdef FP_ADDSUB_RNE_EN
        issue(32'h3F800000, 32'h34400000, 1'b0, 1, 32'h3F800002, 54, 0, 0);
`else
        issue(32'h3F800000, 32'h34400000, 1'b0, 1, 32'h3F800001, 54, 0, 0);
`endif
        issue(32'h80000000, 32'h80000000, 1'b0, 1, 32'h80000000, 2, 1, 0);
        issue(32'h80000000, 32'h00000000, 1'b1, 1, 32'h80000000, 2, 1, 0);
        issue(32'h00000000, 32'h00000000, 1'b1, 1, 32'h00000000, 2, 1, 1);
        issue(32'h7FC00001, 32'h3F800000, 1'b0, 1, 32'h7FC00000, 2, 1, 0);
        issue(32'h3F800000, 32'h7F800000, 1'b1, 1, 32'hFF800000, 2, 1, 0);
        issue(32'h00800000, 32'h00C00000, 1'b1, 1, 32'h80000000, 54, 0, 0);

        for (int i = 0; i < 300; i++) begin
            m  = $urandom_range(0, 3);
            ra = $urandom;
            case (m)
                0: rb = $urandom;
                1: begin
                    rb = $urandom;
                    rb[30:23] = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
                end
                2: rb = ra ^ 32'($urandom_range(0, 255));
                default: begin
                    ra = SP[$urandom_range(0, 7)];
                    rb = ($urandom_range(0, 1) == 1) ? SP[$urandom_range(0, 7)] : $urandom;
                end
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), 0, 32'd0, 54, 0, 1'($urandom_range(0, 1)));
        end

        // Reset during an operation: that result must never be delivered.
        bus.start  = 1'b1;
        bus.a      = 32'h3F800000;
        bus.b      = 32'h40000000;
        bus.op_sub = 1'b1;
        @(posedge clk);
        txq[tx_cnt] = '{model(32'h3F800000, 32'h40000000, 1'b1), 1, 32'hBF800000, cyc + 1, 54, 0};
        tx_cnt++;
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'h40400000, 32'h3F800000, 1'b0, 1, 32'h40800000, 54, 0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
